// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared mode/field encodings and key indices for the clock controller
package clock_ctrl_pkg;
    typedef enum logic [1:0] {MODE_CLOCK, MODE_ALARM, MODE_STOPWATCH, MODE_SET} mode_t;
    typedef enum logic [1:0] {FLD_SEC, FLD_MIN, FLD_HOUR} fld_t;
    localparam int NUM_KEYS   = 7;
    localparam int KEY_DATE   = 0;
    localparam int KEY_MODE   = 1;
    localparam int KEY_FIELD  = 2;
    localparam int KEY_INC    = 3;
    localparam int KEY_DEC    = 4;
    localparam int KEY_SW_RUN = 5;
    localparam int KEY_SW_CLR = 6;
endpackage

// File: rtl/key_prio_arb.sv
// key_prio_arb: one-hot grant of the lowest-index set request bit, purely combinational
module key_prio_arb
    import clock_ctrl_pkg::*;
#(
    parameter int W = NUM_KEYS
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] gnt
);
    assign gnt = req & (~req + W'(1));
endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: mode FSM, edit/stopwatch command strobes and alarm ringing for the digital clock.
// Define AUTO_RETURN_EN to return to CLOCK after TIMEOUT_S idle seconds in ALARM/SET.
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TIMEOUT_S = 30,
    parameter int RING_S    = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_pulse,
    input  logic                tick_1hz,
    input  logic                alarm_match,
    output logic [1:0]          mode,
    output logic                show_date,
    output logic [1:0]          field_sel,
    output logic                adj_inc,
    output logic                adj_dec,
    output logic                alarm_en,
    output logic                sw_run,
    output logic                sw_clear,
    output logic                time_led,
    output logic                beep
);
    if (TIMEOUT_S < 1 || TIMEOUT_S > 255 || RING_S < 1 || RING_S > 255) begin : g_bad_param
        $error("clock_mode_ctrl: TIMEOUT_S and RING_S must lie in 1..255");
    end

    mode_t               st;
    mode_t               mode_nxt;
    logic [NUM_KEYS-1:0] sel;
    logic [7:0]          ring_cnt;
    logic                in_edit;
    logic                timeout;
    logic                mode_chg;

    key_prio_arb #(.W(NUM_KEYS)) u_arb (.req(key_pulse), .gnt(sel));

    assign mode    = st;
    assign in_edit = (st == MODE_ALARM) || (st == MODE_SET);

`ifdef AUTO_RETURN_EN
    logic [7:0] idle_cnt;

    // An accepted key in the timeout cycle wins and keeps the current mode.
    assign timeout = in_edit && tick_1hz && !(|sel) && idle_cnt == 8'(TIMEOUT_S - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (mode_chg || |sel)
            idle_cnt <= '0;
        else if (in_edit && tick_1hz)
            idle_cnt <= idle_cnt + 8'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign mode_chg = (!beep && sel[KEY_MODE]) || timeout;
    assign mode_nxt = timeout ? MODE_CLOCK : mode_t'(st + 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= MODE_CLOCK;
            show_date <= 1'b0;
            field_sel <= FLD_SEC;
            adj_inc   <= 1'b0;
            adj_dec   <= 1'b0;
            alarm_en  <= 1'b1;
            sw_run    <= 1'b0;
            sw_clear  <= 1'b0;
            time_led  <= 1'b0;
            beep      <= 1'b0;
            ring_cnt  <= '0;
        end else begin
            adj_inc  <= 1'b0;
            adj_dec  <= 1'b0;
            sw_clear <= 1'b0;
            if (tick_1hz && in_edit)
                time_led <= ~time_led;
            // While ringing, any accepted key only silences the buzzer.
            if (beep) begin
                if (tick_1hz)
                    ring_cnt <= ring_cnt - 8'd1;
                if (|sel || (tick_1hz && ring_cnt == 8'd1))
                    beep <= 1'b0;
            end else begin
                if (alarm_match && alarm_en) begin
                    beep     <= 1'b1;
                    ring_cnt <= 8'(RING_S);
                end
                if (sel[KEY_DATE] && st == MODE_CLOCK)
                    show_date <= ~show_date;
                if (sel[KEY_DATE] && st == MODE_ALARM)
                    alarm_en <= ~alarm_en;
                if (sel[KEY_FIELD] && st == MODE_SET)
                    field_sel <= (field_sel == FLD_HOUR) ? FLD_SEC : field_sel + 2'd1;
                if (sel[KEY_FIELD] && st == MODE_ALARM)
                    field_sel <= (field_sel == FLD_MIN) ? FLD_HOUR : FLD_MIN;
                adj_inc <= sel[KEY_INC] && in_edit;
                adj_dec <= sel[KEY_DEC] && in_edit;
                if (sel[KEY_SW_RUN] && st == MODE_STOPWATCH)
                    sw_run <= ~sw_run;
                if (sel[KEY_SW_CLR] && st == MODE_STOPWATCH) begin
                    sw_clear <= 1'b1;
                    sw_run   <= 1'b0;
                end
            end
            if (mode_chg) begin
                st        <= mode_nxt;
                show_date <= 1'b0;
                time_led  <= 1'b0;
                if (mode_nxt == MODE_ALARM)
                    field_sel <= FLD_MIN;
                else if (mode_nxt == MODE_SET)
                    field_sel <= FLD_SEC;
            end
        end
    end
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: scoreboard bench for clock_mode_ctrl (TIMEOUT_S=2, RING_S=3)
module tb_clock_mode_ctrl;
    typedef struct packed {
        logic [1:0] mode;
        logic       sd;
        logic [1:0] fs;
        logic       inc;
        logic       dec;
        logic       aen;
        logic       run;
        logic       clr;
        logic       led;
        logic       beep;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
        int    due;
    } sb_t;

    localparam logic [6:0] K_DATE  = 7'b0000001;
    localparam logic [6:0] K_MODE  = 7'b0000010;
    localparam logic [6:0] K_FIELD = 7'b0000100;
    localparam logic [6:0] K_INC   = 7'b0001000;
    localparam logic [6:0] K_DEC   = 7'b0010000;
    localparam logic [6:0] K_RUN   = 7'b0100000;
    localparam logic [6:0] K_CLR   = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] key_pulse = '0;
    logic       tick_1hz = 1'b0;
    logic       alarm_match = 1'b0;
    logic [1:0] mode;
    logic       show_date;
    logic [1:0] field_sel;
    logic       adj_inc;
    logic       adj_dec;
    logic       alarm_en;
    logic       sw_run;
    logic       sw_clear;
    logic       time_led;
    logic       beep;

    obs_t o;
    obs_t e;
    sb_t  sb[$];
    sb_t  cur;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    clock_mode_ctrl #(.TIMEOUT_S(2), .RING_S(3)) dut (
        .clk(clk), .rst(rst), .key_pulse(key_pulse), .tick_1hz(tick_1hz),
        .alarm_match(alarm_match), .mode(mode), .show_date(show_date),
        .field_sel(field_sel), .adj_inc(adj_inc), .adj_dec(adj_dec),
        .alarm_en(alarm_en), .sw_run(sw_run), .sw_clear(sw_clear),
        .time_led(time_led), .beep(beep)
    );

    assign o = {mode, show_date, field_sel, adj_inc, adj_dec, alarm_en, sw_run, sw_clear, time_led, beep};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (mode,sd,fs,inc,dec,aen,run,clr,led,beep)", tag, got, exp);
        end
    endtask

    // Expected outputs are due one edge after the stimulus cycle.
    task automatic step(input logic [6:0] k, input logic t, input logic m, input string tag);
        key_pulse   = k;
        tick_1hz    = t;
        alarm_match = m;
        sb.push_back('{tag, e, cyc + 1});
        e.inc = 1'b0;
        e.dec = 1'b0;
        e.clr = 1'b0;
        @(posedge clk);
        #1;
        key_pulse   = '0;
        tick_1hz    = 1'b0;
        alarm_match = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            check(cur.tag, o, cur.v);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        e = '{mode: 2'd0, sd: 1'b0, fs: 2'd0, inc: 1'b0, dec: 1'b0, aen: 1'b1,
              run: 1'b0, clr: 1'b0, led: 1'b0, beep: 1'b0};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset", o, e);
        e.mode = 2'd1; e.fs = 2'd1; step(K_MODE, 0, 0, "mode_alarm");
        e.mode = 2'd2;              step(K_MODE, 0, 0, "mode_sw");
        e.mode = 2'd3; e.fs = 2'd0; step(K_MODE, 0, 0, "mode_set");
        e.mode = 2'd0;              step(K_MODE, 0, 0, "mode_clock");
        e.sd = 1'b1;                step(K_DATE, 0, 0, "date_on");
        e.mode = 2'd1; e.sd = 1'b0; e.fs = 2'd1; step(K_MODE, 0, 0, "alarm_date_clr");
        e.aen = 1'b0;               step(K_DATE, 0, 0, "aen_off");
        e.aen = 1'b1;               step(K_DATE, 0, 0, "aen_on");
        e.fs = 2'd2;                step(K_FIELD, 0, 0, "alarm_fld_hour");
        e.fs = 2'd1;                step(K_FIELD, 0, 0, "alarm_fld_min");
        e.led = 1'b1;               step('0, 1, 0, "led_toggle");
        e.mode = 2'd2; e.led = 1'b0; step(K_MODE, 0, 0, "sw_led_clr");
        e.run = 1'b1;               step(K_RUN, 0, 0, "run_on");
        e.run = 1'b0;               step(K_RUN, 0, 0, "run_off");
        e.run = 1'b1;               step(K_RUN, 0, 0, "run_on2");
        e.clr = 1'b1; e.run = 1'b0; step(K_CLR, 0, 0, "sw_clear");
                                    step('0, 0, 0, "clr_width");
        e.run = 1'b1;               step(K_RUN, 0, 0, "run_on3");
                                    step(K_FIELD | K_RUN, 0, 0, "arb_drop");
                                    step('0, 1, 0, "led_hold");
        e.mode = 2'd3; e.fs = 2'd0; step(K_MODE, 0, 0, "set_run_keep");
        for (int i = 0; i < 3; i++) begin
            e.inc = 1'b1; step(K_INC, 0, 0, "inc");
                          step('0, 0, 0, "inc_width");
        end
        e.fs = 2'd1;                step(K_FIELD, 0, 0, "set_fld_min");
        e.dec = 1'b1;               step(K_DEC, 0, 0, "dec");
                                    step('0, 0, 0, "dec_width");
        e.inc = 1'b1;               step(K_INC | K_DEC, 0, 0, "arb_inc");
        e.fs = 2'd2;                step(K_FIELD, 0, 0, "set_fld_hour");
        e.fs = 2'd0;                step(K_FIELD, 0, 0, "set_fld_wrap");
        e.mode = 2'd0;              step(K_MODE, 0, 0, "back_clock");
        e.beep = 1'b1;              step('0, 0, 1, "ring_start");
                                    step('0, 1, 0, "ring_t1");
                                    step('0, 1, 0, "ring_t2");
                                    step('0, 0, 1, "match_ignored");
        e.beep = 1'b0;              step('0, 1, 0, "ring_end");
                                    step('0, 1, 0, "ring_quiet");
        e.beep = 1'b1;              step('0, 0, 1, "ring2_start");
                                    step('0, 1, 0, "ring2_t1");
                                    step('0, 1, 0, "ring2_t2");
        e.beep = 1'b0;              step(K_DATE, 1, 0, "key_final_tick");
        e.sd = 1'b1;                step(K_DATE, 0, 0, "date_after_ring");
        e.sd = 1'b0;                step(K_DATE, 0, 0, "date_off");
        e.mode = 2'd1; e.fs = 2'd1; step(K_MODE, 0, 0, "alarm_again");
        e.aen = 1'b0;               step(K_DATE, 0, 0, "disarm");
                                    step('0, 0, 1, "match_disarmed");
        e.aen = 1'b1;               step(K_DATE, 0, 0, "rearm");
        e.mode = 2'd2;              step(K_MODE, 0, 0, "sw_again");
        e.mode = 2'd3; e.fs = 2'd0; step(K_MODE, 0, 0, "set_again");
        e.beep = 1'b1;              step('0, 0, 1, "ring3_start");
        e.led = 1'b1;               step('0, 1, 0, "ring3_tick");
        e.beep = 1'b0;              step(K_INC, 0, 0, "key_stops_ring");
                                    step('0, 0, 0, "no_inc_after");
        e.inc = 1'b1;               step(K_INC, 0, 0, "inc_after_ring");
                                    step('0, 0, 0, "idle");
`ifdef AUTO_RETURN_EN
        e.led = 1'b0;               step('0, 1, 0, "ar_t1");
        e.mode = 2'd0;              step('0, 1, 0, "ar_return");
        e.mode = 2'd1; e.fs = 2'd1; step(K_MODE, 0, 0, "ar_alarm");
        e.mode = 2'd2;              step(K_MODE, 0, 0, "ar_sw");
        e.mode = 2'd3; e.fs = 2'd0; step(K_MODE, 0, 0, "ar_set");
        e.led = 1'b1;               step('0, 1, 0, "ar_k_t1");
        e.led = 1'b0;               step(K_DATE, 1, 0, "ar_key_wins");
        e.led = 1'b1;               step('0, 1, 0, "ar_after_key");
`else
        e.led = 1'b0;               step('0, 1, 0, "nr_t1");
        e.led = 1'b1;               step('0, 1, 0, "no_return");
`endif
        repeat (3) @(posedge clk);
        check("drain", 13'(sb.size()), 13'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
